// File: rtl/ramif_sram_seq64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ramif_sram_seq64 : single-beat ramif request sequencer for a sync SRAM     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ramif_sram_seq64 #(
   parameter int AW    = 17,
   parameter int DEPTH = 2**AW,
   parameter int WCW   = 1
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           ramen,
   input  logic           ramcs,
   input  logic [AW-1:0]  ramaddr,
   input  logic [7:0]     ramwr,
   input  logic [63:0]    ramwdata,
   output logic [63:0]    ramrdata,
   output logic           ramready,
   input  logic [WCW-1:0] waitcyc,
   output logic           sram_ce,
   output logic           sram_we,
   output logic [63:0]    sram_bwe,
   output logic [AW-1:0]  sram_a,
   output logic [63:0]    sram_d,
   input  logic [63:0]    sram_q,
   output logic           oor_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic           accept;
   logic           in_range;
   logic [7:0]     wr_q;
   logic [WCW-1:0] wc_q;
   logic [WCW-1:0] cnt;
   logic [63:0]    bwe_exp;

   assign accept   = (state == IDLE) && ramcs && ramen;
   assign in_range = 64'(ramaddr) < 64'(DEPTH);

   for (genvar i = 0; i < 8; i++) begin : g_bwe
      assign bwe_exp[8*i +: 8] = {8{ramwr[i]}};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = in_range ? ACC : DONE;
         ACC:  state_nx = ((|wr_q) || (wc_q == '0)) ? DONE : WAIT;
         WAIT: if (cnt <= WCW'(1)) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Registered outputs are driven from the next state so they line up with it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ramready <= 1'b0;
         oor_err  <= 1'b0;
         sram_ce  <= 1'b0;
         sram_we  <= 1'b0;
         sram_bwe <= '0;
         sram_a   <= '0;
         sram_d   <= '0;
         ramrdata <= '0;
         wr_q     <= '0;
         wc_q     <= '0;
         cnt      <= '0;
      end else begin
         ramready <= (state_nx == DONE);
         oor_err  <= accept && !in_range;
         sram_ce  <= accept && in_range;
         sram_we  <= 1'b0;
         if (accept) begin
            wr_q <= ramwr;
            wc_q <= waitcyc;
         end
         // Macro pins only move when an in-range access starts.
         if (accept && in_range) begin
            sram_a   <= ramaddr;
            sram_d   <= ramwdata;
            sram_bwe <= bwe_exp;
            sram_we  <= |ramwr;
         end
         if (state == ACC && state_nx == WAIT) cnt <= wc_q;
         else if (state == WAIT)                cnt <= cnt - WCW'(1);
         if (accept && !in_range && ramwr == 8'h00)
            ramrdata <= '0;
         else if ((state == ACC || state == WAIT) && state_nx == DONE && wr_q == 8'h00)
            ramrdata <= sram_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ramif_sram_seq64.sv
`default_nettype none
// Testbench for ramif_sram_seq64: random accesses checked against a transaction-level model.
module tb_ramif_sram_seq64;

   localparam int AW = 11;
   localparam int DEPTH = 1024;
   localparam int WCW = 2;

   logic           clk = 1'b0;
   logic           resetn;
   logic           ramen, ramcs;
   logic [AW-1:0]  ramaddr;
   logic [7:0]     ramwr;
   logic [63:0]    ramwdata, ramrdata;
   logic           ramready;
   logic [WCW-1:0] waitcyc;
   logic           sram_ce, sram_we;
   logic [63:0]    sram_bwe, sram_d, sram_q;
   logic [AW-1:0]  sram_a;
   logic           oor_err;

   int checks = 0;
   int errors = 0;

   logic [63:0] mac_mem   [DEPTH];
   logic [63:0] model_mem [DEPTH];
   logic [63:0] model_rdata;

   always #5 clk = ~clk;

   ramif_sram_seq64 #(.AW(AW), .DEPTH(DEPTH), .WCW(WCW)) dut (
      .clk(clk), .resetn(resetn), .ramen(ramen), .ramcs(ramcs), .ramaddr(ramaddr),
      .ramwr(ramwr), .ramwdata(ramwdata), .ramrdata(ramrdata), .ramready(ramready),
      .waitcyc(waitcyc), .sram_ce(sram_ce), .sram_we(sram_we), .sram_bwe(sram_bwe),
      .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .oor_err(oor_err)
   );

   // Macro model: bit-masked write on a clocked write cycle, read data follows the address.
   assign sram_q = mac_mem[sram_a[9:0]];
   always @(posedge clk) begin
      if (sram_ce && sram_we)
         mac_mem[sram_a[9:0]] = (mac_mem[sram_a[9:0]] & ~sram_bwe) | (sram_d & sram_bwe);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] expand(input logic [7:0] w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (w[i]) r = r | (64'hFF << (8*i));
      return r;
   endfunction

   task automatic access(input logic [AW-1:0] a, input logic [7:0] w, input logic [63:0] d,
                         input logic [WCW-1:0] wc, input int hold, input bit disturb);
      bit          oor;
      bit          bad;
      int          lat, exp_lat, ce_n, we_n;
      logic [63:0] rd;
      logic        oe;
      oor = (int'(a) >= DEPTH);
      @(negedge clk);
      ramaddr = a; ramwr = w; ramwdata = d; waitcyc = wc; ramcs = 1'b1;
      ramen = (hold == 0);
      if (hold > 0) begin
         bad = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (sram_ce || ramready) bad = 1'b1;
         end
         check("ramen_block", 64'(bad), 64'd0);
         ramen = 1'b1;
      end
      lat = 0; ce_n = 0; we_n = 0; rd = '0; oe = 1'b0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check("ce_t1", 64'(sram_ce), 64'(!oor));
            if (!oor) begin
               check("sram_a", 64'(sram_a), 64'(a));
               if (w != 8'h00) begin
                  check("sram_bwe", sram_bwe, expand(w));
                  check("sram_d", sram_d, d);
               end
            end
            if (disturb) begin
               waitcyc = ~wc;
               ramen = 1'b0;
            end
         end
         ce_n += int'(sram_ce);
         we_n += int'(sram_we);
         if (ramready) begin
            lat = n; rd = ramrdata; oe = oor_err; ramcs = 1'b0;
         end
      end
      if (lat == 0) begin
         check("timeout", 64'd0, 64'd1);
         ramcs = 1'b0;
      end
      exp_lat = oor ? 1 : ((w != 8'h00) ? 2 : 2 + int'(wc));
      if (w == 8'h00) model_rdata = oor ? 64'd0 : model_mem[a[9:0]];
      else if (!oor)  model_mem[a[9:0]] = (model_mem[a[9:0]] & ~expand(w)) | (d & expand(w));
      check("latency", 64'(lat), 64'(exp_lat));
      check("rdata", rd, model_rdata);
      check("oor_err", 64'(oe), 64'(oor));
      check("ce_cycles", 64'(ce_n), 64'(!oor));
      check("we_cycles", 64'(we_n), 64'(!oor && w != 8'h00));
      @(negedge clk);
      check("ready_pulse", 64'(ramready), 64'd0);
   endtask

   task automatic reset_mid(input int at);
      @(negedge clk);
      ramaddr = AW'($urandom_range(0, DEPTH-1)); ramwr = 8'h00; waitcyc = 2'd3;
      ramcs = 1'b1; ramen = 1'b1;
      for (int i = 0; i < at; i++) @(negedge clk);
      ramcs = 1'b0;
      #2 resetn = 1'b0;
      #1 check("rst_ce", 64'(sram_ce), 64'd0);
      check("rst_ready", 64'(ramready), 64'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_hold_ready", 64'(ramready), 64'd0);
      end
      check("rst_rdata", ramrdata, 64'd0);
      resetn = 1'b1;
      model_rdata = '0;
   endtask

   initial begin
      bit          pulses_ok;
      int          pulses, p1, p2;
      logic [AW-1:0] a;
      logic [7:0]  w;
      resetn = 1'b0; ramen = 1'b0; ramcs = 1'b0; ramaddr = '0; ramwr = '0;
      ramwdata = '0; waitcyc = '0; model_rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mac_mem[i] = {$urandom, $urandom};
         model_mem[i] = mac_mem[i];
      end
      mac_mem[16] = 64'hDEADBEEF_01234567;
      model_mem[16] = 64'hDEADBEEF_01234567;
      repeat (3) @(negedge clk);
      check("reset_vals", {ramrdata | sram_bwe | sram_d | 64'(sram_a)}, 64'd0);
      check("reset_ctl", 64'({ramready, oor_err, sram_ce, sram_we}), 64'd0);
      resetn = 1'b1;

      access(11'h010, 8'h00, 64'd0, 2'd0, 0, 1'b0);
      access(11'h020, 8'h0F, 64'h11223344_55667788, 2'd0, 0, 1'b0);
      access(11'h020, 8'h00, 64'd0, 2'd3, 0, 1'b1);
      access(11'h400, 8'h00, 64'd0, 2'd2, 0, 1'b0);
      access(11'h7FF, 8'hFF, 64'hCAFE, 2'd1, 0, 1'b0);
      access(11'h3FF, 8'h00, 64'd0, 2'd1, 5, 1'b0);

      // Request held across two reads: second acceptance waits out DONE and one IDLE.
      @(negedge clk);
      ramaddr = 11'h010; ramwr = 8'h00; waitcyc = 2'd0; ramcs = 1'b1; ramen = 1'b1;
      pulses = 0; p1 = 0; p2 = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (ramready) begin
            pulses++;
            if (pulses == 1) p1 = n;
            else begin
               p2 = n;
               ramcs = 1'b0;
               check("b2b_rdata", ramrdata, model_mem[16]);
            end
         end
      end
      ramcs = 1'b0;
      model_rdata = model_mem[16];
      pulses_ok = (pulses == 2) && (p1 == 2) && (p2 == 5);
      check("b2b_pulses", 64'(pulses_ok), 64'd1);

      reset_mid(1);
      reset_mid(2);
      access(11'h010, 8'h00, 64'd0, 2'd1, 0, 1'b0);

      for (int k = 0; k < 60; k++) begin
         a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 2*DEPTH-1))
                                          : AW'($urandom_range(0, 63));
         w = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         access(a, w, {$urandom, $urandom}, WCW'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0) ? 3 : 0, bit'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
